// File: rtl/issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : issue_unit
//  Description : In-order issue stage for a Tomasulo datapath. It takes one
//                decoded instruction at a time and keeps the register status
//                table, which holds the producer tag of each architectural
//                register. For each instruction it picks the lowest free
//                reservation station and resolves both source operands to a
//                value (Vj/Vk) or a producer tag (Qj/Qk). It then pulses that
//                station's load strobe for one cycle. Tags are retired by
//                snooping the common data bus (CDB).
//  Optional    : define ISSUE_STATS_EN to add the o_issue_count and
//                o_stall_count statistics outputs.
//  Ports       :
//    i_clk, i_rst_n              clock (rising edge), synchronous active-low reset
//    i_instr_valid/o_instr_ready instruction handshake
//    i_instr_op/rd/rs/rt         decoded instruction fields
//    o_rf_rs_addr/o_rf_rt_addr   register file read addresses (latched instr)
//    i_rf_rs_data/i_rf_rt_data   register file read data (combinational)
//    i_rs_busy                   busy flag of each reservation station
//    o_opcode, o_r_target        issued opcode / destination register
//    o_vj, o_vk, o_qj, o_qk      issued operand values / producer tags
//    o_enable_vq                 one-hot station load strobe
//    i_cdb_valid/tag/data        common data bus broadcast
//    o_issue_count/o_stall_count statistics (ISSUE_STATS_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_unit #(
   parameter int NUM_RS   = 4,
   parameter int NUM_REGS = 8,
   parameter int DATA_W   = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_instr_valid,
   output logic              o_instr_ready,
   input  logic [2:0]        i_instr_op,
   input  logic [2:0]        i_instr_rd,
   input  logic [2:0]        i_instr_rs,
   input  logic [2:0]        i_instr_rt,
   output logic [2:0]        o_rf_rs_addr,
   output logic [2:0]        o_rf_rt_addr,
   input  logic [DATA_W-1:0] i_rf_rs_data,
   input  logic [DATA_W-1:0] i_rf_rt_data,
   input  logic [NUM_RS-1:0] i_rs_busy,
   output logic [2:0]        o_opcode,
   output logic [2:0]        o_r_target,
   output logic [DATA_W-1:0] o_vj,
   output logic [DATA_W-1:0] o_vk,
   output logic [2:0]        o_qj,
   output logic [2:0]        o_qk,
   output logic [NUM_RS-1:0] o_enable_vq,
   input  logic              i_cdb_valid,
   input  logic [2:0]        i_cdb_tag,
   input  logic [DATA_W-1:0] i_cdb_data
`ifdef ISSUE_STATS_EN
   ,
   output logic [15:0]       o_issue_count,
   output logic [15:0]       o_stall_count
`endif
);

   localparam int          c_TAG_W  = 3;
   localparam int          c_REG_W  = 3;
   localparam logic [0:0]  c_S_IDLE = 1'b0;
   localparam logic [0:0]  c_S_HOLD = 1'b1;

   // ---------------------------------------------------------------- state
   logic [0:0]          r_state;
   logic [0:0]          w_next_state;
   logic                w_instr_ready;

   // Latched instruction waiting for a station
   logic [2:0]          r_op;
   logic [c_REG_W-1:0]  r_rd;
   logic [c_REG_W-1:0]  r_rs;
   logic [c_REG_W-1:0]  r_rt;

   // Register status table and the just-issued station mask
   logic [c_TAG_W-1:0]  r_qi [NUM_REGS];
   logic [NUM_RS-1:0]   r_pending;

   // Issued outputs
   logic [2:0]          r_opcode;
   logic [2:0]          r_r_target;
   logic [DATA_W-1:0]   r_vj;
   logic [DATA_W-1:0]   r_vk;
   logic [c_TAG_W-1:0]  r_qj;
   logic [c_TAG_W-1:0]  r_qk;
   logic [NUM_RS-1:0]   r_enable_vq;

   // Combinational helpers
   logic                w_accept;
   logic [NUM_RS-1:0]   w_cand;
   logic                w_issue;
   logic [c_TAG_W-1:0]  w_sel;
   logic [c_TAG_W-1:0]  w_new_tag;
   logic [NUM_RS-1:0]   w_onehot;
   logic                w_cdb_hit;
   logic [c_TAG_W-1:0]  w_qi_rs;
   logic [c_TAG_W-1:0]  w_qi_rt;
   logic [DATA_W-1:0]   w_vj;
   logic [DATA_W-1:0]   w_vk;
   logic [c_TAG_W-1:0]  w_qj;
   logic [c_TAG_W-1:0]  w_qk;

   // ------------------------------------------------------ FSM: state reg
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------ FSM: next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_S_IDLE: if (i_instr_valid) w_next_state = c_S_HOLD;
         c_S_HOLD: if (|w_cand)       w_next_state = c_S_IDLE;
         default:                     w_next_state = c_S_IDLE;
      endcase
   end

   // ------------------------------------------------------ FSM: outputs
   always_comb begin
      w_instr_ready = 1'b0;
      if (r_state == c_S_IDLE) w_instr_ready = 1'b1;
   end

   assign w_accept = (r_state == c_S_IDLE) && i_instr_valid;

   // A station is free when it is not busy and was not loaded on the
   // previous edge (its busy flag may not have caught up yet).
   assign w_cand  = ~i_rs_busy & ~r_pending;
   assign w_issue = (r_state == c_S_HOLD) && (|w_cand);

   // Lowest-index free station wins
   always_comb begin
      w_sel = '0;
      for (int k = NUM_RS - 1; k >= 0; k--) begin
         if (w_cand[k]) w_sel = c_TAG_W'(k);
      end
   end

   assign w_new_tag = w_sel + 3'd1;
   assign w_onehot  = NUM_RS'(1) << w_sel;
   assign w_cdb_hit = i_cdb_valid && (i_cdb_tag != '0);

   // Operand resolution: ready value, same-cycle CDB bypass, or wait on tag.
   // The old status entry is read here, so rd==rs/rt sees the previous tag.
   assign w_qi_rs = r_qi[r_rs];
   assign w_qi_rt = r_qi[r_rt];

   always_comb begin
      w_vj = '0;
      w_qj = '0;
      if (w_qi_rs == '0) begin
         w_vj = i_rf_rs_data;
      end else if (i_cdb_valid && (i_cdb_tag == w_qi_rs)) begin
         w_vj = i_cdb_data;
      end else begin
         w_qj = w_qi_rs;
      end
   end

   always_comb begin
      w_vk = '0;
      w_qk = '0;
      if (w_qi_rt == '0) begin
         w_vk = i_rf_rt_data;
      end else if (i_cdb_valid && (i_cdb_tag == w_qi_rt)) begin
         w_vk = i_cdb_data;
      end else begin
         w_qk = w_qi_rt;
      end
   end

   // ------------------------------------------------------ datapath
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_op        <= '0;
         r_rd        <= '0;
         r_rs        <= '0;
         r_rt        <= '0;
         r_pending   <= '0;
         r_opcode    <= '0;
         r_r_target  <= '0;
         r_vj        <= '0;
         r_vk        <= '0;
         r_qj        <= '0;
         r_qk        <= '0;
         r_enable_vq <= '0;
         for (int x = 0; x < NUM_REGS; x++) r_qi[x] <= '0;
      end else begin
         if (w_accept) begin
            r_op <= i_instr_op;
            r_rd <= i_instr_rd;
            r_rs <= i_instr_rs;
            r_rt <= i_instr_rt;
         end

         r_pending   <= w_issue ? w_onehot : '0;
         r_enable_vq <= w_issue ? w_onehot : '0;

         if (w_issue) begin
            r_opcode   <= r_op;
            r_r_target <= r_rd;
            r_vj       <= w_vj;
            r_vk       <= w_vk;
            r_qj       <= w_qj;
            r_qk       <= w_qk;
         end

         // Issue write to rd takes priority over a CDB clear of the same entry
         for (int x = 0; x < NUM_REGS; x++) begin
            if (w_issue && (r_rd == c_REG_W'(x))) begin
               r_qi[x] <= w_new_tag;
            end else if (w_cdb_hit && (r_qi[x] == i_cdb_tag)) begin
               r_qi[x] <= '0;
            end
         end
      end
   end

`ifdef ISSUE_STATS_EN
   logic [15:0] r_issue_count;
   logic [15:0] r_stall_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_issue_count <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_issue) r_issue_count <= r_issue_count + 16'd1;
         if ((r_state == c_S_HOLD) && !(|w_cand)) r_stall_count <= r_stall_count + 16'd1;
      end
   end

   assign o_issue_count = r_issue_count;
   assign o_stall_count = r_stall_count;
`endif

   assign o_instr_ready = w_instr_ready;
   assign o_rf_rs_addr  = r_rs;
   assign o_rf_rt_addr  = r_rt;
   assign o_opcode      = r_opcode;
   assign o_r_target    = r_r_target;
   assign o_vj          = r_vj;
   assign o_vk          = r_vk;
   assign o_qj          = r_qj;
   assign o_qk          = r_qk;
   assign o_enable_vq   = r_enable_vq;

endmodule
`default_nettype wire

// File: tb/tb_issue_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_issue_unit
//  Description : Directed self-checking bench for issue_unit. A small register
//                file model answers the combinational read ports; station busy
//                flags and CDB broadcasts are driven by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_unit;

   localparam int NUM_RS = 4;
   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              instr_valid;
   logic              instr_ready;
   logic [2:0]        instr_op, instr_rd, instr_rs, instr_rt;
   logic [2:0]        rf_rs_addr, rf_rt_addr;
   logic [DATA_W-1:0] rf_rs_data, rf_rt_data;
   logic [NUM_RS-1:0] rs_busy;
   logic [2:0]        opcode, r_target;
   logic [DATA_W-1:0] vj, vk;
   logic [2:0]        qj, qk;
   logic [NUM_RS-1:0] enable_vq;
   logic              cdb_valid;
   logic [2:0]        cdb_tag;
   logic [DATA_W-1:0] cdb_data;
`ifdef ISSUE_STATS_EN
   logic [15:0]       issue_count, stall_count;
`endif

   logic [DATA_W-1:0] rf [8];
   int                n_vec  = 0;
   int                n_fail = 0;

   always #5 clk = ~clk;

   always_comb rf_rs_data = rf[rf_rs_addr];
   always_comb rf_rt_data = rf[rf_rt_addr];

   issue_unit #(.NUM_RS(NUM_RS), .NUM_REGS(8), .DATA_W(DATA_W)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_instr_valid (instr_valid),
      .o_instr_ready (instr_ready),
      .i_instr_op    (instr_op),
      .i_instr_rd    (instr_rd),
      .i_instr_rs    (instr_rs),
      .i_instr_rt    (instr_rt),
      .o_rf_rs_addr  (rf_rs_addr),
      .o_rf_rt_addr  (rf_rt_addr),
      .i_rf_rs_data  (rf_rs_data),
      .i_rf_rt_data  (rf_rt_data),
      .i_rs_busy     (rs_busy),
      .o_opcode      (opcode),
      .o_r_target    (r_target),
      .o_vj          (vj),
      .o_vk          (vk),
      .o_qj          (qj),
      .o_qk          (qk),
      .o_enable_vq   (enable_vq),
      .i_cdb_valid   (cdb_valid),
      .i_cdb_tag     (cdb_tag),
      .i_cdb_data    (cdb_data)
`ifdef ISSUE_STATS_EN
      ,
      .o_issue_count (issue_count),
      .o_stall_count (stall_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for a single accepting edge; returns in HOLD
   task automatic offer(input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [2:0] rt);
      instr_valid = 1'b1;
      instr_op    = op;
      instr_rd    = rd;
      instr_rs    = rs;
      instr_rt    = rt;
      tick();
      instr_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rf[i] = 16'h0100 + 16'(i);
      rf[2] = 16'h0005;
      rf[3] = 16'h0007;

      rst_n       = 1'b0;
      instr_valid = 1'b0;
      instr_op    = '0;
      instr_rd    = '0;
      instr_rs    = '0;
      instr_rt    = '0;
      rs_busy     = '0;
      cdb_valid   = 1'b0;
      cdb_tag     = '0;
      cdb_data    = '0;

      // ---- reset state
      tick();
      tick();
      check("rst_ready",  32'(instr_ready), 32'd1);
      check("rst_enable", 32'(enable_vq),   32'h0);
      check("rst_opcode", 32'(opcode),      32'h0);
      check("rst_vj",     32'(vj),          32'h0);
      check("rst_qk",     32'(qk),          32'h0);
      rst_n = 1'b1;

      // ---- ADD r1 = r2 + r3, all stations free -> station 0
      offer(3'd1, 3'd1, 3'd2, 3'd3);
      check("add_hold_ready", 32'(instr_ready), 32'd0);
      check("add_rf_rs_addr", 32'(rf_rs_addr),  32'd2);
      check("add_hold_en",    32'(enable_vq),   32'h0);
      tick();
      check("add_en",     32'(enable_vq), 32'b0001);
      check("add_vj",     32'(vj),        32'h0005);
      check("add_vk",     32'(vk),        32'h0007);
      check("add_qj",     32'(qj),        32'd0);
      check("add_qk",     32'(qk),        32'd0);
      check("add_rtgt",   32'(r_target),  32'd1);
      check("add_op",     32'(opcode),    32'd1);
      rs_busy = 4'b0001;
      tick();
      check("add_en_pulse", 32'(enable_vq),   32'h0);
      check("add_op_held",  32'(opcode),      32'd1);
      check("add_ready",    32'(instr_ready), 32'd1);

      // ---- SUB r4 = r1 - r1: both sides wait on tag 1 -> station 1
      offer(3'd2, 3'd4, 3'd1, 3'd1);
      tick();
      check("sub_en",   32'(enable_vq), 32'b0010);
      check("sub_qj",   32'(qj),        32'd1);
      check("sub_qk",   32'(qk),        32'd1);
      check("sub_vj",   32'(vj),        32'h0);
      check("sub_vk",   32'(vk),        32'h0);
      check("sub_rtgt", 32'(r_target),  32'd4);

      // ---- all stations busy for 5 cycles, then station 2 frees up
      rs_busy = 4'b1111;
      offer(3'd3, 3'd2, 3'd4, 3'd5);
      for (int c = 0; c < 5; c++) begin
         tick();
         check("stall_ready", 32'(instr_ready), 32'd0);
         check("stall_en",    32'(enable_vq),   32'h0);
      end
      rs_busy = 4'b1011;
      tick();
      check("unstall_en", 32'(enable_vq), 32'b0100);
      check("unstall_qj", 32'(qj),        32'd2);
      check("unstall_qk", 32'(qk),        32'd0);
      check("unstall_vk", 32'(vk),        32'h0105);
`ifdef ISSUE_STATS_EN
      check("stat_issue", 32'(issue_count), 32'd3);
      check("stat_stall", 32'(stall_count), 32'd5);
`endif

      // ---- Qi[2]=3; CDB broadcasts tag 3 during HOLD -> bypass on rs=2
      rs_busy = 4'b0111;
      offer(3'd4, 3'd6, 3'd2, 3'd4);
      cdb_valid = 1'b1;
      cdb_tag   = 3'd3;
      cdb_data  = 16'hBEEF;
      tick();
      cdb_valid = 1'b0;
      check("byp_en", 32'(enable_vq), 32'b1000);
      check("byp_vj", 32'(vj),        32'hBEEF);
      check("byp_qj", 32'(qj),        32'd0);
      check("byp_qk", 32'(qk),        32'd2);

      // ---- CDB tag 1 collides with issue of rd=1 (also rs=1) to station 2
      rs_busy = 4'b1011;
      offer(3'd5, 3'd1, 3'd1, 3'd6);
      cdb_valid = 1'b1;
      cdb_tag   = 3'd1;
      cdb_data  = 16'h1234;
      tick();
      cdb_valid = 1'b0;
      check("col_en", 32'(enable_vq), 32'b0100);
      check("col_vj", 32'(vj),        32'h1234);
      check("col_qj", 32'(qj),        32'd0);
      check("col_qk", 32'(qk),        32'd4);

      // ---- Qi[1] must now be 3 and Qi[2] cleared by the earlier broadcast
      rs_busy = 4'b1101;
      offer(3'd6, 3'd7, 3'd1, 3'd2);
      tick();
      check("qi_en", 32'(enable_vq), 32'b0010);
      check("qi1_q", 32'(qj),        32'd3);
      check("qi1_v", 32'(vj),        32'h0);
      check("qi2_q", 32'(qk),        32'd0);
      check("qi2_v", 32'(vk),        32'h0005);

      // ---- reset while stalled in HOLD discards the instruction
      rs_busy = 4'b1111;
      offer(3'd7, 3'd5, 3'd0, 3'd0);
      tick();
      check("pre_rst_ready", 32'(instr_ready), 32'd0);
      rst_n = 1'b0;
      tick();
      check("mid_rst_ready", 32'(instr_ready), 32'd1);
      check("mid_rst_en",    32'(enable_vq),   32'h0);
      check("mid_rst_op",    32'(opcode),      32'h0);
      check("mid_rst_qj",    32'(qj),          32'h0);
      rst_n   = 1'b1;
      rs_busy = 4'b0000;
      tick();
      check("post_rst_en",    32'(enable_vq),   32'h0);
      check("post_rst_ready", 32'(instr_ready), 32'd1);
      offer(3'd1, 3'd3, 3'd1, 3'd7);
      tick();
      check("clr_en", 32'(enable_vq), 32'b0001);
      check("clr_qj", 32'(qj),        32'd0);
      check("clr_qk", 32'(qk),        32'd0);
      check("clr_vj", 32'(vj),        32'h0101);
      check("clr_vk", 32'(vk),        32'h0107);
`ifdef ISSUE_STATS_EN
      check("stat_rst_issue", 32'(issue_count), 32'd1);
      check("stat_rst_stall", 32'(stall_count), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/issue_unit.md
Name: issue_unit

Overview:
- In-order issue stage for the Tomasulo datapath; drives the reservation stations.
- Accepts one decoded instruction at a time and keeps the register status table (producer tag per architectural register).
- Selects a free reservation station and resolves each source operand to either a value (Vj/Vk) or a producer tag (Qj/Qk).
- Pulses that station's write enable for one cycle; snoops the common data bus (CDB) to retire tags.

Parameters:
NUM_RS, 4, number of reservation stations (1..7); station i owns tag i+1, tag 0 = no dependency
NUM_REGS, 8, architectural registers, indices 0..NUM_REGS-1
DATA_W, 16, operand width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset
Instr_valid  in  1  instruction offered
Instr_ready  out  1  issue unit can accept instruction
Instr_op  in  3  opcode
Instr_rd  in  3  destination register
Instr_rs  in  3  source j register
Instr_rt  in  3  source k register
Rf_rs_addr  out  3  register file read address j (combinational from latched instr)
Rf_rt_addr  out  3  register file read address k
Rf_rs_data  in  DATA_W  register file read data j (combinational read)
Rf_rt_data  in  DATA_W  register file read data k
Rs_busy  in  NUM_RS  Busy of each station
Opcode  out  3  issued opcode
R_target  out  3  issued destination register
Vj, Vk  out  DATA_W  operand values
Qj, Qk  out  3  operand producer tags
Enable_VQ  out  NUM_RS  one-hot station load strobe
Cdb_valid  in  1  CDB broadcast valid
Cdb_tag  in  3  producing station tag
Cdb_data  in  DATA_W  broadcast result

Behaviour:
- Reset (Reset=0 at rising edge):
  - State IDLE; all status entries Qi[*]=0; pending mask=0.
  - Enable_VQ=0; Opcode, R_target, Vj, Vk, Qj, Qk = 0; Instr_ready=1 in the cycle after.
  - Applies mid-operation: a latched, unissued instruction is discarded.
- States:
  - IDLE: Instr_ready=1. On Instr_valid=1, latch op/rd/rs/rt and go to HOLD.
  - HOLD: Instr_ready=0. Free stations: candidates = ~Rs_busy & ~pending. If candidates≠0, pick the lowest index i, issue, return to IDLE; otherwise stay in HOLD (stall).
- Issue (registered, at the HOLD edge with a free station):
  - Enable_VQ = 1<<i for exactly one cycle.
  - Opcode, R_target, Vj/Vk, Qj/Qk valid in the same cycle and held until the next issue.
  - Latency: instruction accepted at edge N, Enable_VQ high in cycle after edge N+1 with no stall.
- Operand resolution, per source r, evaluated in the HOLD cycle:
  - Qi[r]==0: V=Rf data, Q=0.
  - Else if Cdb_valid and Cdb_tag==Qi[r]: V=Cdb_data, Q=0 (bypass).
  - Else: V=0, Q=Qi[r].
  - rs==rt is resolved identically on both sides.
- Status update at issue: Qi[rd] <= i+1; pending[i] set for one cycle, masking the station while Rs_busy lags the strobe.
- CDB snoop, every cycle Cdb_valid=1 with Cdb_tag≠0:
  - Every Qi[x]==Cdb_tag clears to 0.
  - Same-edge collision with an issue on rd: the issue write wins for rd.
  - Cdb_tag=0 is ignored.
- Back-to-back: IDLE/HOLD alternation gives a maximum throughput of one issue per 2 cycles.
- An instruction whose rd equals its own rs/rt reads the old tag first, then overwrites Qi[rd].

Optional Feature:
- Macro ISSUE_STATS_EN.
- Defined: adds outputs Issue_count[15:0] and Stall_count[15:0].
  - Issue_count increments per issue; Stall_count increments per HOLD cycle with no free station.
  - Both wrap at 0xFFFF->0 and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset low 2 cycles then high, offer ADD rd=1 rs=2 rt=3 with Rf data 0x0005/0x0007, all Rs_busy=0 -> Enable_VQ=0001 one cycle, Vj=5, Vk=7, Qj=Qk=0, R_target=1, Qi[1]=1.
- Follow with SUB rd=4 rs=1 rt=1 -> issue to station 1 (Enable_VQ=0010), Qj=Qk=1, Vj=Vk=0, Qi[4]=2.
- Rs_busy=1111 for 5 cycles with instruction latched -> Instr_ready=0, no Enable_VQ, Stall_count+5 (ISSUE_STATS_EN); then Rs_busy=1011 -> Enable_VQ=0100.
- Qi[2]=3, issue rs=2 while Cdb_valid=1, Cdb_tag=3, Cdb_data=0xBEEF -> Vj=0xBEEF, Qj=0, Qi[2]=0.
- CDB tag 1 and issue with rd=1 to station 2 on the same edge -> Qi[1]=3 (not 0).
- Reset low while in HOLD -> next cycle IDLE, Enable_VQ never pulses, all Qi=0.
